// File: rtl/jtcop_objdma_pkg.sv
// jtcop_objdma_pkg: shared FSM states and default sizes for the object DMA
package jtcop_objdma_pkg;
  localparam int OBJDMA_AW = 10;
  localparam int OBJDMA_DW = 16;
  typedef enum logic [2:0] {IDLE, REQ, GRANT, RD, WR, DONE} state_t;
endpackage

// File: rtl/jtcop_objdma_if.sv
// jtcop_objdma_if: trigger, 68000 arbitration, object RAM and object buffer signals of the DMA
interface jtcop_objdma_if import jtcop_objdma_pkg::*; #(
  parameter int AW = OBJDMA_AW,
  parameter int DW = OBJDMA_DW
);
  logic          i_obj_copy;
  logic          i_asn;
  logic          i_bgn;
  logic          o_brn;
  logic          o_bgackn;
  logic [AW-1:0] o_ram_addr;
  logic          o_ram_cs;
  logic [DW-1:0] i_ram_dout;
  logic          i_ram_ok;
  logic [AW-1:0] o_buf_addr;
  logic [DW-1:0] o_buf_din;
  logic          o_buf_we;
  logic          o_busy;
  logic          o_done;
  modport master (
    input  i_obj_copy, i_asn, i_bgn, i_ram_dout, i_ram_ok,
    output o_brn, o_bgackn, o_ram_addr, o_ram_cs, o_buf_addr, o_buf_din, o_buf_we, o_busy, o_done
  );
  modport slave (
    output i_obj_copy, i_asn, i_bgn, i_ram_dout, i_ram_ok,
    input  o_brn, o_bgackn, o_ram_addr, o_ram_cs, o_buf_addr, o_buf_din, o_buf_we, o_busy, o_done
  );
endinterface

// File: rtl/jtcop_objdma.sv
// jtcop_objdma: copies object RAM into the object buffer on obj_copy; define JTCOP_OBJDMA_HALT_EN to halt the 68000 via BRn/BGn/BGACKn during the copy
module jtcop_objdma import jtcop_objdma_pkg::*; #(
  parameter int AW = OBJDMA_AW,
  parameter int DW = OBJDMA_DW
) (
  input  logic clk,
  input  logic rst,
  jtcop_objdma_if.master bus
);
`ifdef JTCOP_OBJDMA_HALT_EN
  localparam state_t FIRST = REQ;
`else
  localparam state_t FIRST = RD;
`endif
  state_t        r_state, w_next;
  logic [AW-1:0] r_cnt;
  logic [DW-1:0] r_data;
  logic          r_pend;
  logic          w_start, w_last;
  assign w_start = bus.i_obj_copy | r_pend;
  assign w_last  = &r_cnt;
  // state register; reset aborts any copy in flight without a done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  // next state: waits in REQ and RD are unbounded by design
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  w_next = w_start ? FIRST : IDLE;
`ifdef JTCOP_OBJDMA_HALT_EN
      REQ:   w_next = (!bus.i_bgn && bus.i_asn) ? GRANT : REQ;
      GRANT: w_next = RD;
`endif
      RD:    w_next = bus.i_ram_ok ? WR : RD;
      WR:    w_next = w_last ? DONE : RD;
      DONE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // outputs decoded from state so reset releases the bus immediately
  always_comb begin
`ifdef JTCOP_OBJDMA_HALT_EN
    bus.o_brn    = r_state != REQ;
    bus.o_bgackn = !(r_state inside {GRANT, RD, WR});
`else
    bus.o_brn    = 1'b1;
    bus.o_bgackn = 1'b1;
`endif
    bus.o_ram_cs   = r_state == RD;
    bus.o_buf_we   = r_state == WR;
    bus.o_busy     = r_state inside {REQ, GRANT, RD, WR};
    bus.o_done     = r_state == DONE;
    bus.o_ram_addr = r_cnt;
    bus.o_buf_addr = r_cnt;
    bus.o_buf_din  = r_data;
  end
  // word counter, read data latch and one-deep retrigger flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_data <= '0;
      r_pend <= 1'b0;
    end else begin
      r_pend <= r_state == IDLE ? 1'b0 : r_pend | bus.i_obj_copy;
      r_cnt  <= r_state == IDLE ? '0 : (r_state == WR && !w_last) ? r_cnt + 1'b1 : r_cnt;
      if (r_state == RD && bus.i_ram_ok) r_data <= bus.i_ram_dout;
    end
  end
endmodule

// File: tb/tb_jtcop_objdma.sv
// tb_jtcop_objdma: table-driven random copies against a word-list/timing model, plus reset and retrigger sequences
module tb_jtcop_objdma;
  localparam int AW = 4;
  localparam int DW = 16;
  localparam int N  = 1 << AW;

  typedef struct {int lat_max; int gnt_dly; int as_low; int extra; int exp_copies;} vec_t;
  typedef struct {logic [AW-1:0] a; logic [DW-1:0] d;} wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  jtcop_objdma_if #(.AW(AW), .DW(DW)) bus();
  jtcop_objdma #(.AW(AW), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  logic [DW-1:0] mem [N];
  wr_t wq[$];
  int  dq[$], rsq[$], bq[$], gq[$], lat_q[$];
  int  cyc = 0, errors = 0, checks = 0, viol = 0;
  int  lat_max = 1, gnt_dly = 0, as_low = 0;
  int  k_rd = 0, l_rd = 0, wc = 0;
  logic p_brn = 1'b1, p_bgk = 1'b1, seen = 1'b0;

  function automatic void chk(string nm, logic signed [31:0] act, logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  function automatic int qat(int q[$], int i);
    return i < q.size() ? q[i] : -1;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // object RAM: data valid after a random 1..lat_max clk latency (1 = same clk as cs)
  always @(posedge clk) begin
    #1;
    if (bus.o_ram_cs) begin
      if (k_rd == 0) begin
        l_rd = $urandom_range(1, lat_max);
        lat_q.push_back(l_rd);
      end
      k_rd++;
      bus.i_ram_ok   = k_rd >= l_rd;
      bus.i_ram_dout = k_rd >= l_rd ? mem[bus.o_ram_addr] : DW'($urandom);
    end else begin
      k_rd = 0;
      bus.i_ram_ok = 1'b0;
    end
  end

  // 68000 arbiter: grant gnt_dly clk after BRn, current bus cycle ends as_low clk later
  always @(posedge clk) begin
    #1;
    if (!bus.o_brn) begin
      bus.i_bgn = !(wc >= gnt_dly);
      bus.i_asn = !(wc < gnt_dly + as_low);
      wc++;
    end else begin
      wc = 0;
      bus.i_bgn = 1'b1;
      bus.i_asn = 1'($urandom_range(0, 1));
    end
  end

  // monitor: log writes, done pulses, copy starts and bus handshake edges
  always @(negedge clk) begin
    if (rst) seen = 1'b0;
    else begin
      if (bus.o_buf_we) wq.push_back('{bus.o_buf_addr, bus.o_buf_din});
      if (bus.o_done) dq.push_back(cyc);
      if (bus.o_ram_cs && !seen) begin
        rsq.push_back(cyc);
        seen = 1'b1;
      end
      if (bus.o_done) seen = 1'b0;
      if (!bus.o_brn && p_brn) bq.push_back(cyc);
      if (!bus.o_bgackn && p_bgk) gq.push_back(cyc);
`ifdef JTCOP_OBJDMA_HALT_EN
      if (((bus.o_ram_cs || bus.o_buf_we) && bus.o_bgackn) || (!bus.o_brn && !bus.o_bgackn)) viol++;
`else
      if (!bus.o_brn || !bus.o_bgackn) viol++;
`endif
    end
    p_brn = bus.o_brn;
    p_bgk = bus.o_bgackn;
  end

  task automatic clr();
    wq.delete(); dq.delete(); rsq.delete(); bq.delete(); gq.delete(); lat_q.delete();
  endtask

  task automatic fill_mem();
    foreach (mem[i]) mem[i] = DW'($urandom);
  endtask

  task automatic check_words(string nm, int copies);
    int bad = 0;
    chk({nm, "_wr_cnt"}, wq.size(), N * copies);
    foreach (wq[i]) if (wq[i].a !== AW'(i % N) || wq[i].d !== mem[i % N]) bad++;
    chk({nm, "_wr_seq_bad"}, bad, 0);
  endtask

  task automatic check_restart(string nm);
`ifdef JTCOP_OBJDMA_HALT_EN
    chk({nm, "_restart"}, qat(bq, 1), qat(dq, 0) + 2);
`else
    chk({nm, "_restart"}, qat(rsq, 1), qat(dq, 0) + 2);
`endif
  endtask

  task automatic run_vec(vec_t v, string nm);
    int k = 0, tail = 0, t0, s = -1;
    lat_max = v.lat_max; gnt_dly = v.gnt_dly; as_low = v.as_low;
    fill_mem();
    clr();
    @(posedge clk); #1;
    bus.i_obj_copy = 1'b1;
    t0 = cyc;
    for (int n = 0; n < 4000 && tail < 40; n++) begin
      @(posedge clk); #1;
      bus.i_obj_copy = 1'b0;
      if (k < v.extra && dq.size() == 0 && wq.size() >= 3 * (k + 1)) begin
        bus.i_obj_copy = 1'b1;
        k++;
      end
      if (dq.size() >= v.exp_copies) tail++;
    end
    chk({nm, "_done_cnt"}, dq.size(), v.exp_copies);
    check_words(nm, v.exp_copies);
    if (rsq.size() > 0 && lat_q.size() >= N) begin
      s = rsq[0];
      for (int i = 0; i < N; i++) s += lat_q[i] + 1;
    end
    chk({nm, "_done_time"}, qat(dq, 0), s);
`ifdef JTCOP_OBJDMA_HALT_EN
    chk({nm, "_req_time"}, qat(bq, 0), t0 + 1);
    chk({nm, "_gnt_time"}, qat(gq, 0), qat(bq, 0) + v.gnt_dly + v.as_low + 1);
    chk({nm, "_rd_time"}, qat(rsq, 0), qat(gq, 0) + 1);
`else
    chk({nm, "_rd_time"}, qat(rsq, 0), t0 + 1);
`endif
    if (v.exp_copies > 1) check_restart(nm);
    chk({nm, "_busy_end"}, bus.o_busy, 0);
  endtask

  vec_t vecs[6];

  initial begin
    int tail = 0;
    logic fired = 1'b0;
    vecs[0] = '{1, 3, 0, 0, 1};
    vecs[1] = '{1, 0, 5, 0, 1};
    vecs[2] = '{6, 1, 0, 0, 1};
    vecs[3] = '{3, 2, 2, 2, 2};
    vecs[4] = '{4, 0, 0, 1, 2};
    vecs[5] = '{1, 0, 0, 3, 2};
    bus.i_obj_copy = 1'b0;
    bus.i_ram_ok   = 1'b0;
    bus.i_ram_dout = '0;
    bus.i_bgn      = 1'b1;
    bus.i_asn      = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_brn_bgackn", {bus.o_brn, bus.o_bgackn}, 2'b11);
    chk("rst_cs_we_done", {bus.o_ram_cs, bus.o_buf_we, bus.o_done}, 3'b000);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_addr", {bus.o_ram_addr, bus.o_buf_addr}, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("v%0d", i));

    // reset in the middle of a copy
    lat_max = 2; gnt_dly = 1; as_low = 0;
    fill_mem();
    clr();
    @(posedge clk); #1;
    bus.i_obj_copy = 1'b1;
    @(posedge clk); #1;
    bus.i_obj_copy = 1'b0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (bus.o_buf_we && bus.o_buf_addr == AW'(7)) break;
    end
    #2 rst = 1'b1;
    #1;
    chk("midrst_brn_bgackn", {bus.o_brn, bus.o_bgackn}, 2'b11);
    chk("midrst_busy", bus.o_busy, 0);
    chk("midrst_cs_we_done", {bus.o_ram_cs, bus.o_buf_we, bus.o_done}, 3'b000);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("midrst_no_done", dq.size(), 0);
    chk("midrst_wr_cnt", wq.size(), 8);
    run_vec('{2, 1, 1, 0, 1}, "after_rst");

    // obj_copy landing in the DONE clk queues exactly one more copy
    lat_max = 2; gnt_dly = 0; as_low = 0;
    fill_mem();
    clr();
    @(posedge clk); #1;
    bus.i_obj_copy = 1'b1;
    for (int n = 0; n < 4000 && tail < 40; n++) begin
      @(posedge clk); #1;
      bus.i_obj_copy = 1'b0;
      if (bus.o_done && !fired) begin
        bus.i_obj_copy = 1'b1;
        fired = 1'b1;
      end
      if (dq.size() >= 2) tail++;
    end
    chk("done_retrig_done_cnt", dq.size(), 2);
    check_words("done_retrig", 2);
    check_restart("done_retrig");

    chk("handshake_violations", viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
